twocomp_serial: RTL and testbench
=================================

// Module: twocomp_serial
// PURPOSE
//  Bit-serial two's-complement negator: accepts a W-bit word over a valid/ready handshake and processes it
//  LSB-first, one bit per clock. Rule: copy bits up to and including the first 1, invert every bit after it.
//  Returns the negated word in parallel over a second valid/ready handshake.
//  Sits between the operand source and the signed-arithmetic stages as a low-area alternative to the
//  parallel gate-level negator.
// PARAMETERS
//  W    3    operand/result width in bits (>=2)
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst        in   1  reset; synchronous, active-high
//  in_valid   in   1  a_in holds a valid operand
//  in_ready   out  1  block can accept an operand this cycle
//  a_in       in   W  operand, two's complement
//  out_valid  out  1  s_out holds the result
//  out_ready  in   1  consumer takes the result this cycle
//  s_out      out  W  -a_in mod 2^W
//  busy       out  1  high while in SHIFT
// BEHAVIOUR
//  - Reset: rst=1 at a rising edge puts the FSM in IDLE and clears all registers.
//    Reset values: in_ready=1, out_valid=0, s_out=0, busy=0.
//    Reset mid-SHIFT or in DONE discards the word; no partial result is ever presented.
//  - FSM states: IDLE, SHIFT, DONE. Next-state logic is a registered one-hot or 2-bit encoding.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid&&in_ready: load a_in into shift reg sr, clear seen_one, clear bit count cnt, go to SHIFT.
//  - SHIFT:
//    - in_ready=0, busy=1.
//    - Each cycle: b = sr[0]; r = seen_one ? ~b : b.
//    - Shift r into the result reg MSB end, then shift right.
//    - seen_one <= seen_one | b.
//    - cnt <= cnt+1.
//    - After W cycles (cnt==W-1 processed) go to DONE.
//  - DONE:
//    - out_valid=1; s_out is stable and must not change while out_valid && !out_ready.
//    - On out_ready: go to IDLE.
//    - in_ready stays 0 in DONE; no bypass.
//  - Timing: operand accepted at edge k; out_valid rises after edge k+W.
//    - Minimum interval between accepted operands: W+2 cycles.
//  - Boundary cases:
//    - a_in=0: seen_one never set, so s_out=0.
//    - a_in=most-negative (1 followed by zeros): s_out equals a_in (wraps, no saturation).
//    - in_valid while busy: ignored; the source must hold it until in_ready.
//    - out_ready while !out_valid: no effect.
//  - cnt width: $clog2(W)+1 bits; no wrap issues.
// CONFIGURATION
//  TWOCOMP_SERIAL_OVF_EN:
//    - Defined: adds output port ovf (1 bit), registered with s_out.
//      ovf=1 iff the operand was the most-negative value (2^(W-1)).
//      Detect as a_in[W-1] && ~|a_in[W-2:0] at load.
//      Held with s_out; reset 0.
//    - Undefined: no ovf port and no detection logic.
// STRUCTURE
//  - Package twocomp_pkg:
//    - state enum/localparams (ST_IDLE, ST_SHIFT, ST_DONE)
//    - function is_most_neg(W).
//  - One sub-module, twocomp_bit_cell: per-bit datapath.
//    - Combinational part: seen_one, b -> r.
//    - Registered part: seen_one flag with clear/enable.
//  - Top level holds the FSM, sr, result reg, cnt and handshake.
// TESTING (W=3)
//  1. rst high 2 cycles -> in_ready=1, out_valid=0, s_out=000, busy=0.
//  2. a_in=011, out_ready=1 -> s_out=101, out_valid 3 edges after accept, held 1 cycle.
//     Repeat for all 8 inputs -> 000,111,110,101,100,011,010,001.
//  3. a_in=100 -> s_out=100; with TWOCOMP_SERIAL_OVF_EN, ovf=1. a_in=110 -> s_out=010, ovf=0.
//  4. Backpressure: out_ready=0 for 5 cycles after a_in=001 -> s_out=111 stable, out_valid=1, in_ready=0.
//     Then out_ready=1 -> IDLE next cycle.
//  5. rst asserted mid-SHIFT (after 1 bit of a_in=010) -> next cycle IDLE, out_valid=0, no result.
//     Next operand 011 -> 101.
//  6. in_valid held high continuously with changing a_in while busy
//     -> only words sampled at in_ready are negated, back-to-back every 5 cycles.

Source files
------------

// File: rtl/twocomp_pkg.sv
// ---------------------------------------------------------------------------
// twocomp_pkg
//   Shared definitions for the bit-serial two's-complement negator.
//   - state_t      : FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//   - is_most_neg  : true when the low w bits of v are 1 followed by zeros
//                    (the one value whose negation wraps onto itself)
// ---------------------------------------------------------------------------
package twocomp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_most_neg(input logic [31:0] v, input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (v & mask) == (32'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/twocomp_bit_cell.sv
// ---------------------------------------------------------------------------
// twocomp_bit_cell
//   One-bit datapath of the serial negator: copy bits until the first 1 has
//   gone past, invert every bit after that.
// Ports
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   clr       in   clear seen_one (new operand loaded)
//   en        in   a bit is being processed this cycle
//   b         in   current operand bit (LSB first)
//   r         out  result bit for this cycle (combinational)
//   seen_one  out  registered flag: a 1 has already been processed
// ---------------------------------------------------------------------------
module twocomp_bit_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic b,
    output logic r,
    output logic seen_one
);

    // The first 1 is itself copied, because seen_one only rises after it.
    assign r = seen_one ? ~b : b;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values, independent of block ordering.
        if (rst || clr) begin
            seen_one <= 1'b0;
        end else if (en) begin
            seen_one <= seen_one | b;
        end
    end

endmodule

// File: rtl/twocomp_serial.sv
// ---------------------------------------------------------------------------
// twocomp_serial
//   Bit-serial two's-complement negator. Accepts a W-bit operand over a
//   valid/ready handshake, processes it LSB-first one bit per clock, and
//   presents -a_in mod 2^W in parallel over a second valid/ready handshake.
//   Operand accepted at edge k -> out_valid rises after edge k+W.
// Parameters
//   W          operand/result width (>= 2)
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   a_in holds a valid operand
//   in_ready   out  operand can be accepted this cycle (IDLE only)
//   a_in       in   W-bit operand
//   out_valid  out  s_out holds the result (DONE)
//   out_ready  in   consumer takes the result this cycle
//   s_out      out  W-bit result, stable while out_valid
//   busy       out  high while shifting
//   ovf        out  (only with TWOCOMP_SERIAL_OVF_EN) operand was the
//                   most-negative value; updated together with s_out
// Configuration
//   TWOCOMP_SERIAL_OVF_EN  adds the ovf port and its detection logic.
// ---------------------------------------------------------------------------
module twocomp_serial
    import twocomp_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s_out,
    output logic         busy
`ifdef TWOCOMP_SERIAL_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t          state;
    logic [W-1:0]    sr;       // operand, shifted right one bit per cycle
    logic [W-2:0]    res;      // result bits collected so far, MSB-aligned
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            shifting;
    logic            r;
    logic            seen_one;

`ifdef TWOCOMP_SERIAL_OVF_EN
    logic            ovf_pend;
`endif

    assign accept   = (state == ST_IDLE) && in_valid && in_ready;
    assign shifting = (state == ST_SHIFT);

    twocomp_bit_cell u_cell (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .en       (shifting),
        .b        (sr[0]),
        .r        (r),
        .seen_one (seen_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sr        <= '0;
            res       <= '0;
            cnt       <= '0;
            s_out     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef TWOCOMP_SERIAL_OVF_EN
            ovf_pend  <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sr       <= a_in;
                        res      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
`ifdef TWOCOMP_SERIAL_OVF_EN
                        ovf_pend <= is_most_neg(32'(a_in), W);
`endif
                    end
                end

                ST_SHIFT: begin
                    sr  <= sr >> 1;
                    // Keep the top W-1 bits of {r, res} shifted right; the
                    // full word is only assembled when it goes to s_out.
                    res <= (W-1)'({r, res} >> 1);
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        s_out     <= {r, res};
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_DONE;
`ifdef TWOCOMP_SERIAL_OVF_EN
                        ovf       <= ovf_pend;
`endif
                    end
                end

                ST_DONE: begin
                    // s_out is untouched here, so it holds under backpressure.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twocomp_serial.sv
// ---------------------------------------------------------------------------
// tb_twocomp_serial
//   Directed self-checking bench for twocomp_serial with W=3.
//   Define TWOCOMP_SERIAL_OVF_EN for both RTL and bench to cover ovf.
// ---------------------------------------------------------------------------
module tb_twocomp_serial;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s_out;
    logic         busy;
`ifdef TWOCOMP_SERIAL_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Hand-computed -a mod 8 for a = 0..7.
    logic [W-1:0] neg_tab [8] = '{3'b000, 3'b111, 3'b110, 3'b101,
                                  3'b100, 3'b011, 3'b010, 3'b001};

    twocomp_serial #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_out     (s_out),
        .busy      (busy)
`ifdef TWOCOMP_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (in_ready) break;
            tick();
        end
        check("ready_timeout", int'(in_ready), 1);
    endtask

    // One transaction with out_ready held high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] exp, input logic exp_ovf);
        wait_ready();
        in_valid = 1'b1;
        a_in     = a;
        tick();                               // accept edge k
        in_valid = 1'b0;
        check("op_busy", int'(busy), 1);
        check("op_in_ready_low", int'(in_ready), 0);
        repeat (W - 1) tick();
        check("op_early_valid", int'(out_valid), 0);
        tick();                               // edge k+W
        check("op_valid", int'(out_valid), 1);
        check("op_s_out", int'(s_out), int'(exp));
`ifdef TWOCOMP_SERIAL_OVF_EN
        check("op_ovf", int'(ovf), int'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected x in ovf expectation");
`endif
        tick();
        check("op_valid_1cyc", int'(out_valid), 0);
        check("op_back_idle", int'(in_ready), 1);
    endtask

    initial begin
        logic [W-1:0] exp_q [$];
        logic [W-1:0] e;
        logic         was_ready;
        int           n_acc;
        int           n_res;
        int           last_acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a_in      = '0;
        out_ready = 1'b1;

        // 1. reset state
        tick();
        tick();
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_s_out", int'(s_out), 0);
        check("rst_busy", int'(busy), 0);
`ifdef TWOCOMP_SERIAL_OVF_EN
        check("rst_ovf", int'(ovf), 0);
`endif
        rst = 1'b0;
        tick();

        // 2. every operand
        for (int a = 0; a < 8; a++) begin
            run_op(3'(a), neg_tab[a], (a == 4));
        end

        // 3. boundary operands
        run_op(3'b100, 3'b100, 1'b1);
        run_op(3'b110, 3'b010, 1'b0);

        // 4. backpressure
        out_ready = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        a_in     = 3'b001;
        tick();
        in_valid = 1'b0;
        repeat (W) tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_s_out", int'(s_out), 7);
            check("bp_in_ready", int'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_ready", int'(in_ready), 1);
        check("bp_release_busy", int'(busy), 0);

        // 5. reset in the middle of SHIFT
        in_valid = 1'b1;
        a_in     = 3'b010;
        tick();
        in_valid = 1'b0;
        tick();                               // one bit processed
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_s_out", int'(s_out), 0);
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("mid_rst_no_result", int'(out_valid), 0);
        end
        run_op(3'b011, 3'b101, 1'b0);

        // 6. in_valid held high with changing operand
        n_acc    = 0;
        n_res    = 0;
        last_acc = -1;
        in_valid = 1'b1;
        for (int i = 0; i < 22; i++) begin
            a_in      = 3'(i * 3 + 1);
            was_ready = in_ready;
            tick();
            if (was_ready) begin
                exp_q.push_back(neg_tab[a_in]);
                if (last_acc >= 0) check("bb_interval", i - last_acc, W + 2);
                last_acc = i;
                n_acc++;
            end
            if (out_valid) begin
                check("bb_expected_result", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("bb_s_out", int'(s_out), int'(e));
                end
                n_res++;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("bb_s_out", int'(s_out), int'(e));
                end
                n_res++;
            end
        end
        check("bb_accepts", n_acc, 5);
        check("bb_results", n_res, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
